div3_residue_checker: RTL

Self-checking stimulus and check stage wrapped around the registered 16-bit divide-by-3 remainder stage. It generates 16-bit operands from an LFSR and drives them upstream into the remainder stage. It consumes the 2-bit remainder the stage produces and compares it against a bit-serial golden mod-3 FSM, counting mismatches. It is used for on-chip/in-bench self-test of the constant-division datapath.

---
 rtl/div3_residue_checker.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div3_residue_checker.sv
// Self-test wrapper for the divide-by-3 remainder stage. It drives LFSR operands
// and checks each returned remainder against a bit-serial mod-3 residue.
module div3_residue_checker #(
  parameter int unsigned N_WORDS = 256,
  parameter logic [16:1] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [16:1] X_out,
  input  logic [2:1]  R_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [16:1] err_cnt,
  output logic [16:1] word_cnt,
  output logic [16:1] first_bad_x
);

  // state  | meaning
  // IDLE   | waiting for start, results cleared by reset
  // LOAD   | latch next LFSR operand onto X_out
  // SERIAL | 16 cycles of MSB-first mod-3 reduction
  // CHECK  | compare remainder stage against golden residue
  // DONE   | run complete, results held
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SERIAL, S_CHECK, S_DONE} state_t;

  localparam logic [16:1] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [16:1] N_LAST   = N_WORDS[15:0];

  state_t      r_state, w_state_nxt;
  logic [16:1] r_lfsr, r_sh;
  logic [2:1]  r_res;
  logic [4:1]  r_bit;

  logic [16:1] w_lfsr_nxt;
  logic [16:1] w_word_inc;
  logic [2:1]  w_res_nxt;
  logic        w_start_run;
  logic        w_mismatch;
  logic        w_last_word;

  assign w_lfsr_nxt  = {1'b0, r_lfsr[16:2]} ^ (r_lfsr[1] ? 16'hB400 : 16'h0000);
  assign w_word_inc  = word_cnt + 16'd1;
  assign w_last_word = (w_word_inc == N_LAST);
  assign w_mismatch  = (R_in != r_res);
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // (2r + b) mod 3 without arithmetic, r held in {0,1,2}
  always_comb begin
    w_res_nxt = 2'd0;
    case (r_res)
      2'd0:    w_res_nxt = {1'b0, r_sh[16]};
      2'd1:    w_res_nxt = r_sh[16] ? 2'd0 : 2'd2;
      2'd2:    w_res_nxt = r_sh[16] ? 2'd2 : 2'd1;
      default: w_res_nxt = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_SERIAL;
      S_SERIAL: if (r_bit == 4'd15) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_last_word ? S_DONE : S_LOAD;
      S_DONE:   if (start) w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_out       <= '0;
      r_lfsr      <= SEED_EFF;
      r_sh        <= '0;
      r_res       <= '0;
      r_bit       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= '0;
      word_cnt    <= '0;
      first_bad_x <= '0;
    end else begin
      busy <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SERIAL) ||
              (w_state_nxt == S_CHECK);
      done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_run) begin
            err         <= 1'b0;
            err_cnt     <= '0;
            word_cnt    <= '0;
            first_bad_x <= '0;
            r_lfsr      <= SEED_EFF;
          end
        end
        S_LOAD: begin
          X_out  <= r_lfsr;
          r_sh   <= r_lfsr;
          r_res  <= '0;
          r_bit  <= '0;
          r_lfsr <= w_lfsr_nxt;
        end
        S_SERIAL: begin
          r_res <= w_res_nxt;
          r_sh  <= {r_sh[15:1], 1'b0};
          r_bit <= r_bit + 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            err <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (!err) first_bad_x <= X_out;
          end
          word_cnt <= w_word_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
